// File: rtl/tag_mem_ctrl.sv
// Tag-memory front end: arbitrates the single tag port between the core tag path and a
// word-granular fill engine, with bounded starvation of the fill engine under core load.
module tag_mem_ctrl #(
    parameter int unsigned SIZE      = 8192,
    parameter int unsigned TAG_WIDTH = 4,
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned MAX_STALL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 core_req,
    output logic                 core_gnt,
    output logic                 core_rvalid,
    input  logic [31:0]          core_addr,
    input  logic                 core_we,
    input  logic [3:0]           core_be,
    input  logic [TAG_WIDTH-1:0] core_wdata_tag,
    output logic [TAG_WIDTH-1:0] core_rdata_tag,
    input  logic                 fill_start,
    input  logic [31:0]          fill_base,
    input  logic [LEN_WIDTH-1:0] fill_len,
    input  logic [TAG_WIDTH-1:0] fill_tag,
    input  logic                 fill_abort,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 fill_err,
    output logic                 tm_req,
    input  logic                 tm_gnt,
    input  logic                 tm_rvalid,
    output logic [31:0]          tm_addr,
    output logic                 tm_we,
    output logic [3:0]           tm_be,
    output logic [TAG_WIDTH-1:0] tm_wdata_tag,
    input  logic [TAG_WIDTH-1:0] tm_rdata_tag
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [STALL_W-1:0]   stall_cnt;
    logic                 owner_q;
    logic                 err_q, err_d;

    logic                 fill_want;
    logic                 sel_fill;
    logic                 fill_hs;
    logic                 start_bad;
    logic [32:0]          fill_end;

    // End address is computed one bit wider so a base near 4 GiB cannot wrap into range.
    assign fill_end  = {1'b0, fill_base} + {{(31 - LEN_WIDTH){1'b0}}, fill_len, 2'b00};
    assign start_bad = (fill_base[1:0] != 2'b00) || (fill_end > 33'(SIZE));

    assign fill_want = (state_q == FILL) && !fill_abort;
    assign sel_fill  = fill_want && (!core_req || stall_cnt == STALL_MAX);
    assign fill_hs   = sel_fill && tm_gnt;

    // NOTE: state and counters use non-blocking assignments so every flop samples the
    // same pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else if (fill_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                        addr_d  = fill_base;
                        rem_d   = fill_len;
                    end
                end
            end
            FILL: begin
                if (fill_abort) begin
                    state_d = DONE;
                end else if (fill_hs) begin
                    addr_d = addr_q + 32'd4;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fill_busy = (state_q == FILL);
        fill_done = (state_q == DONE);
        fill_err  = err_q;
        tm_req    = core_req || fill_want;
        core_gnt  = core_req && !sel_fill && tm_gnt;
        if (sel_fill) begin
            tm_addr      = addr_q;
            tm_we        = 1'b1;
            tm_be        = 4'hF;
            tm_wdata_tag = fill_tag;
        end else begin
            tm_addr      = core_addr;
            tm_we        = core_we;
            tm_be        = core_be;
            tm_wdata_tag = core_wdata_tag;
        end
    end

    // Counts core wins against a waiting fill write; at MAX_STALL the fill takes the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!fill_want || fill_hs) begin
            stall_cnt <= '0;
        end else if (core_gnt && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Responses arrive one cycle after their handshake; only core handshakes own them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) owner_q <= 1'b0;
        else        owner_q <= core_gnt;
    end

    assign core_rvalid    = tm_rvalid && owner_q;
    assign core_rdata_tag = tm_rdata_tag;

endmodule

// File: tb/tb_tag_mem_ctrl.sv
// Self-checking bench for tag_mem_ctrl: table of per-cycle vectors with expected port values,
// a one-cycle-latency tag memory model, and a response scoreboard for core_rvalid/rdata.
module tb_tag_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req, core_gnt, core_rvalid, core_we;
    logic [31:0] core_addr;
    logic [3:0]  core_be, core_wdata_tag, core_rdata_tag;
    logic        fill_start, fill_abort, fill_busy, fill_done, fill_err;
    logic [31:0] fill_base;
    logic [15:0] fill_len;
    logic [3:0]  fill_tag;
    logic        tm_req, tm_gnt, tm_we;
    logic        tm_rvalid = 1'b0;
    logic [31:0] tm_addr;
    logic [3:0]  tm_be, tm_wdata_tag;
    logic [3:0]  tm_rdata_tag = 4'h0;

    always #5 clk = ~clk;

    tag_mem_ctrl #(.SIZE(8192), .TAG_WIDTH(4), .LEN_WIDTH(16), .MAX_STALL(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_addr(core_addr), .core_we(core_we), .core_be(core_be),
        .core_wdata_tag(core_wdata_tag), .core_rdata_tag(core_rdata_tag),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_tag(fill_tag), .fill_abort(fill_abort), .fill_busy(fill_busy),
        .fill_done(fill_done), .fill_err(fill_err),
        .tm_req(tm_req), .tm_gnt(tm_gnt), .tm_rvalid(tm_rvalid), .tm_addr(tm_addr),
        .tm_we(tm_we), .tm_be(tm_be), .tm_wdata_tag(tm_wdata_tag), .tm_rdata_tag(tm_rdata_tag)
    );

    // Word-granular tag memory, one response per handshake one cycle later.
    logic [3:0] mem [0:2047];
    always @(posedge clk) begin
        tm_rvalid <= tm_req && tm_gnt;
        if (tm_req && tm_gnt) begin
            tm_rdata_tag <= mem[tm_addr[12:2]];
            if (tm_we) mem[tm_addr[12:2]] <= tm_wdata_tag;
        end
    end

    typedef struct packed {
        logic        start;
        logic [31:0] base;
        logic [15:0] len;
        logic [3:0]  tag;
        logic        abort;
        logic        creq;
        logic [31:0] caddr;
        logic        cwe;
        logic        gnt;
    } in_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [3:0]  wtag;
        logic        gnt;
        logic        busy;
        logic        done;
        logic        err;
        logic        rv;
        logic        rchk;
        logic [3:0]  rtag;
    } exp_t;

    typedef struct {
        string name;
        in_t   i;
        exp_t  e;
    } vec_t;

    typedef struct packed {
        logic       chk;
        logic [3:0] tag;
    } rsp_t;

    vec_t vecs[$];
    rsp_t rsp_q[$];
    int   total = 0;
    int   passed = 0;

    logic [45:0] outs;
    assign outs = {tm_req, tm_we, tm_be, tm_addr, tm_wdata_tag,
                   core_gnt, fill_busy, fill_done, fill_err};

    function automatic logic [45:0] pack_exp(input exp_t e);
        return {e.req, e.we, e.be, e.addr, e.wtag, e.gnt, e.busy, e.done, e.err};
    endfunction

    function automatic in_t i_n(input logic [3:0] tag);
        in_t i;
        i = '0;
        i.tag = tag;
        i.gnt = 1'b1;
        return i;
    endfunction

    function automatic in_t i_s(input logic [31:0] base, input logic [15:0] len,
                                input logic [3:0] tag);
        in_t i;
        i = i_n(tag);
        i.start = 1'b1;
        i.base  = base;
        i.len   = len;
        return i;
    endfunction

    function automatic in_t i_c(input logic [31:0] addr, input logic we, input logic [3:0] tag);
        in_t i;
        i = i_n(tag);
        i.creq  = 1'b1;
        i.caddr = addr;
        i.cwe   = we;
        return i;
    endfunction

    // Core passthrough uses be=3 and wdata tag 6, distinct from the fill values.
    function automatic exp_t e_none(input logic busy, input logic done, input logic err);
        exp_t e;
        e = '0;
        e.be   = 4'h3;
        e.wtag = 4'h6;
        e.busy = busy;
        e.done = done;
        e.err  = err;
        return e;
    endfunction

    function automatic exp_t e_fill(input logic [31:0] addr, input logic [3:0] tag);
        exp_t e;
        e = '0;
        e.req  = 1'b1;
        e.we   = 1'b1;
        e.be   = 4'hF;
        e.addr = addr;
        e.wtag = tag;
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_core(input logic [31:0] addr, input logic we, input logic busy,
                                    input logic done, input logic [3:0] rtag);
        exp_t e;
        e = e_none(busy, done, 1'b0);
        e.req  = 1'b1;
        e.we   = we;
        e.addr = addr;
        e.gnt  = 1'b1;
        e.rv   = 1'b1;
        e.rchk = !we;
        e.rtag = rtag;
        return e;
    endfunction

    task automatic add(input string name, input in_t i, input exp_t e);
        vec_t v;
        v.name = name;
        v.i    = i;
        v.e    = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input in_t i);
        fill_start = i.start;
        fill_base  = i.base;
        fill_len   = i.len;
        fill_tag   = i.tag;
        fill_abort = i.abort;
        core_req   = i.creq;
        core_addr  = i.caddr;
        core_we    = i.cwe;
        tm_gnt     = i.gnt;
    endtask

    task automatic step(input vec_t v);
        rsp_t r;
        logic exp_rv;
        drive(v.i);
        if (v.e.rv) rsp_q.push_back({v.e.rchk, v.e.rtag});
        #1;
        check({v.name, " outputs"}, 64'(outs), 64'(pack_exp(v.e)));
        @(posedge clk);
        #1;
        exp_rv = (rsp_q.size() != 0);
        check({v.name, " rvalid"}, 64'(core_rvalid), 64'(exp_rv));
        if (exp_rv) begin
            r = rsp_q.pop_front();
            if (r.chk) check({v.name, " rdata"}, 64'(core_rdata_tag), 64'(r.tag));
        end
    endtask

    initial begin
        core_be        = 4'h0;
        core_wdata_tag = 4'h0;
        drive(i_n(4'h0));

        // Basic fill of four words, core idle.
        add("f1 start", i_s(32'h100, 16'd4, 4'hA), e_none(0, 0, 0));
        add("f1 w0",    i_n(4'hA), e_fill(32'h100, 4'hA));
        add("f1 w1",    i_n(4'hA), e_fill(32'h104, 4'hA));
        add("f1 w2",    i_n(4'hA), e_fill(32'h108, 4'hA));
        add("f1 w3",    i_n(4'hA), e_fill(32'h10C, 4'hA));
        add("f1 done",  i_n(4'hA), e_none(0, 1, 0));
        add("f1 idle",  i_n(4'hA), e_none(0, 0, 0));
        // Core reads every cycle during a fill: the fill wins every fifth handshake.
        begin
            in_t sc;
            sc = i_s(32'h200, 16'd2, 4'h5);
            sc.creq  = 1'b1;
            sc.caddr = 32'h100;
            add("st c0", sc, e_core(32'h100, 0, 0, 0, 4'hA));
        end
        for (int k = 1; k <= 4; k++)
            add("st core", i_c(32'h100, 0, 4'h5), e_core(32'h100, 0, 1, 0, 4'hA));
        add("st fill0", i_c(32'h100, 0, 4'h5), e_fill(32'h200, 4'h5));
        for (int k = 6; k <= 9; k++)
            add("st core", i_c(32'h100, 0, 4'h5), e_core(32'h100, 0, 1, 0, 4'hA));
        add("st fill1", i_c(32'h100, 0, 4'h5), e_fill(32'h204, 4'h5));
        add("st done",  i_c(32'h100, 0, 4'h5), e_core(32'h100, 0, 0, 1, 4'hA));
        add("st idle",  i_n(4'h5), e_none(0, 0, 0));
        // Core reads back filled tags and its own write.
        add("rd 104",   i_c(32'h104, 0, 4'h0), e_core(32'h104, 0, 0, 0, 4'hA));
        add("rd gap",   i_n(4'h0), e_none(0, 0, 0));
        add("wr 108",   i_c(32'h108, 1, 4'h0), e_core(32'h108, 1, 0, 0, 4'h0));
        add("rd 108",   i_c(32'h108, 0, 4'h0), e_core(32'h108, 0, 0, 0, 4'h6));
        add("rd idle",  i_n(4'h0), e_none(0, 0, 0));
        // Rejected and degenerate starts, plus the exact-fit boundary.
        add("rj over",  i_s(32'h1FFC, 16'd2, 4'h1), e_none(0, 0, 0));
        add("rj over e", i_n(4'h1), e_none(0, 0, 1));
        add("rj align", i_s(32'h101, 16'd1, 4'h1), e_none(0, 0, 0));
        add("rj align e", i_n(4'h1), e_none(0, 0, 1));
        add("rj wrap",  i_s(32'hFFFF_FFFC, 16'd2, 4'h1), e_none(0, 0, 0));
        add("rj wrap e", i_n(4'h1), e_none(0, 0, 1));
        add("len0",     i_s(32'h300, 16'd0, 4'h1), e_none(0, 0, 0));
        add("len0 done", i_n(4'h1), e_none(0, 1, 0));
        add("fit start", i_s(32'h1FF8, 16'd2, 4'h9), e_none(0, 0, 0));
        add("fit w0",   i_n(4'h9), e_fill(32'h1FF8, 4'h9));
        add("fit w1",   i_n(4'h9), e_fill(32'h1FFC, 4'h9));
        add("fit done", i_n(4'h9), e_none(0, 1, 0));
        add("fit idle", i_n(4'h9), e_none(0, 0, 0));
        // Abort after two writes; a start during FILL is ignored.
        add("ab start", i_s(32'h400, 16'd8, 4'h7), e_none(0, 0, 0));
        add("ab w0",    i_n(4'h7), e_fill(32'h400, 4'h7));
        add("ab w1",    i_s(32'h500, 16'd1, 4'h7), e_fill(32'h404, 4'h7));
        begin
            in_t ab;
            ab = i_n(4'h7);
            ab.abort = 1'b1;
            add("ab abort", ab, e_none(1, 0, 0));
        end
        add("ab done",  i_n(4'h7), e_none(0, 1, 0));
        add("ab idle",  i_n(4'h7), e_none(0, 0, 0));
        add("ab again", i_s(32'h500, 16'd1, 4'h7), e_none(0, 0, 0));
        add("ab w2",    i_n(4'h7), e_fill(32'h500, 4'h7));
        add("ab done2", i_n(4'h7), e_none(0, 1, 0));
        add("ab idle2", i_n(4'h7), e_none(0, 0, 0));
        // Memory back-pressure holds the fill write on the same address.
        add("bp start", i_s(32'h600, 16'd1, 4'h2), e_none(0, 0, 0));
        begin
            in_t bp;
            bp = i_n(4'h2);
            bp.gnt = 1'b0;
            add("bp hold", bp, e_fill(32'h600, 4'h2));
        end
        add("bp w0",    i_n(4'h2), e_fill(32'h600, 4'h2));
        add("bp done",  i_n(4'h2), e_none(0, 1, 0));
        add("bp idle",  i_n(4'h2), e_none(0, 0, 0));

        #2;
        check("reset state", 64'({outs, core_rvalid}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        core_be        = 4'h3;
        core_wdata_tag = 4'h6;

        for (int k = 0; k < vecs.size(); k++) step(vecs[k]);

        // Reset in the middle of a fill with a core response in flight.
        step('{"rs start", i_s(32'h40, 16'd8, 4'hB), e_none(0, 0, 0)});
        step('{"rs w0", i_n(4'hB), e_fill(32'h40, 4'hB)});
        drive(i_c(32'h100, 0, 4'hB));
        #1;
        check("rs core gnt", 64'(core_gnt), 64'(1));
        @(posedge clk);
        #1;
        core_be        = 4'h0;
        core_wdata_tag = 4'h0;
        drive(i_n(4'hB));
        rst_n = 1'b0;
        #1;
        check("rs outputs", 64'({outs, core_rvalid}), 64'(0));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("rs held", 64'({outs, core_rvalid}), 64'(0));
        end
        rst_n          = 1'b1;
        core_be        = 4'h3;
        core_wdata_tag = 4'h6;
        rsp_q.delete();
        for (int k = 0; k < 3; k++) step('{"rs quiet", i_n(4'hB), e_none(0, 0, 0)});
        step('{"rs restart", i_s(32'h700, 16'd1, 4'hB), e_none(0, 0, 0)});
        step('{"rs w", i_n(4'hB), e_fill(32'h700, 4'hB)});
        step('{"rs done", i_n(4'hB), e_none(0, 1, 0)});
        step('{"rs idle", i_n(4'hB), e_none(0, 0, 0)});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
